ipsum_buffer: RTL and testbench



---
 rtl/ipsum_buffer.sv | 111 +++++++++++
 tb/tb_ipsum_buffer.sv | 289 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/ipsum_buffer.sv
`default_nettype none
// ============================================================================
// Module      : ipsum_buffer
// Description : Unpacks 32-bit GLB words into per-row 16-bit partial sums and
//               presents the full row vector to the PE array once filled.
// Revision    : 1.0
// ============================================================================
module ipsum_buffer #(
    parameter int ROW_NUM = 32,
    parameter int DATA_W  = 16,
    parameter int BUS_W   = 32
) (
    input  logic                      clk,
    input  logic                      reset,
    input  logic                      start,
    input  logic [5:0]                row_en,
    input  logic                      glb_valid,
    input  logic [BUS_W-1:0]          glb_data,
    output logic                      glb_ready,
    output logic                      ipsum_valid,
    input  logic                      consume,
    output logic [ROW_NUM*DATA_W-1:0] ipsum_out,
    output logic [4:0]                fill_cnt
);

    localparam logic [6:0] c_ROW_MAX = 7'(ROW_NUM);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_FILL = 2'd1,
        S_FULL = 2'd2
    } state_t;

    state_t                          state_q, state_d;
    logic [5:0]                      n_q, n_d;
    logic [4:0]                      last_q, last_d;
    logic [4:0]                      fill_cnt_q, fill_cnt_d;
    logic [ROW_NUM-1:0][DATA_W-1:0]  rows_q, rows_d;

    always_comb begin
        state_d    = state_q;
        n_d        = n_q;
        last_d     = last_q;
        fill_cnt_d = fill_cnt_q;
        rows_d     = rows_q;

        unique case (state_q)
            S_IDLE: begin
                if (start && (row_en != 6'd0) && ({1'b0, row_en} <= c_ROW_MAX)) begin
                    n_d        = row_en;
                    // Index of the final word: ceil(N/2) - 1
                    last_d     = 5'((row_en - 6'd1) >> 1);
                    fill_cnt_d = '0;
                    rows_d     = '0;
                    state_d    = S_FILL;
                end
            end
            S_FILL: begin
                // glb_ready is high throughout FILL, so glb_valid alone is the handshake
                if (glb_valid) begin
                    for (int r = 0; r < ROW_NUM; r++) begin
                        if (5'(r / 2) == fill_cnt_q) begin
                            if ((r % 2) == 0) begin
                                rows_d[r] = glb_data[BUS_W-1 -: DATA_W];
                            end else if (7'(r) < {1'b0, n_q}) begin
                                rows_d[r] = glb_data[DATA_W-1:0];
                            end
                        end
                    end
                    if (fill_cnt_q == last_q) begin
                        fill_cnt_d = '0;
                        state_d    = S_FULL;
                    end else begin
                        fill_cnt_d = fill_cnt_q + 5'd1;
                    end
                end
            end
            S_FULL: begin
                if (consume) begin
                    state_d = S_IDLE;
                end
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q    <= S_IDLE;
            n_q        <= '0;
            last_q     <= '0;
            fill_cnt_q <= '0;
            rows_q     <= '0;
        end else begin
            state_q    <= state_d;
            n_q        <= n_d;
            last_q     <= last_d;
            fill_cnt_q <= fill_cnt_d;
            rows_q     <= rows_d;
        end
    end

    assign glb_ready   = (state_q == S_FILL);
    assign ipsum_valid = (state_q == S_FULL);
    assign fill_cnt    = fill_cnt_q;
    assign ipsum_out   = rows_q;

endmodule
`default_nettype wire

// File: tb/tb_ipsum_buffer.sv
`default_nettype none
// ============================================================================
// Module      : tb_ipsum_buffer
// Description : Scoreboard bench for ipsum_buffer fill/consume behaviour.
// Revision    : 1.0
// ============================================================================
module tb_ipsum_buffer;

    localparam int ROWS = 32;
    localparam int VW   = ROWS * 16;
    typedef logic [VW-1:0] vec_t;

    logic        clk = 1'b0;
    logic        reset = 1'b0;
    logic        start = 1'b0;
    logic [5:0]  row_en = '0;
    logic        glb_valid = 1'b0;
    logic [31:0] glb_data = '0;
    logic        glb_ready;
    logic        ipsum_valid;
    logic        consume = 1'b0;
    vec_t        ipsum_out;
    logic [4:0]  fill_cnt;

    vec_t sb[$];
    vec_t last_vec = '0;
    int   total = 0;
    int   bad = 0;

    ipsum_buffer #(.ROW_NUM(32), .DATA_W(16), .BUS_W(32)) dut (
        .clk        (clk),
        .reset      (reset),
        .start      (start),
        .row_en     (row_en),
        .glb_valid  (glb_valid),
        .glb_data   (glb_data),
        .glb_ready  (glb_ready),
        .ipsum_valid(ipsum_valid),
        .consume    (consume),
        .ipsum_out  (ipsum_out),
        .fill_cnt   (fill_cnt)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Expected placement of word k for an N-row fill
    function automatic vec_t put_word(vec_t v, int k, logic [31:0] w, int n);
        vec_t r;
        r = v;
        r[(2*k)*16 +: 16] = w[31:16];
        if (2*k + 1 < n) r[(2*k+1)*16 +: 16] = w[15:0];
        return r;
    endfunction

    task automatic do_start(input logic [5:0] n);
        start  = 1'b1;
        row_en = n;
        tick();
        start  = 1'b0;
    endtask

    task automatic pulse_consume();
        consume = 1'b1;
        tick();
        consume = 1'b0;
    endtask

    task automatic test_reset();
        reset = 1'b1;
        repeat (2) @(posedge clk);
        #3 reset = 1'b0;
        tick();
        total++; if (glb_ready !== 1'b0) begin bad++; $display("FAIL rst_ready got=%b exp=0", glb_ready); end
        total++; if (ipsum_valid !== 1'b0) begin bad++; $display("FAIL rst_valid got=%b exp=0", ipsum_valid); end
        total++; if (fill_cnt !== 5'd0) begin bad++; $display("FAIL rst_fill_cnt got=%0d exp=0", fill_cnt); end
        total++; if (ipsum_out !== '0) begin bad++; $display("FAIL rst_rows got=%h exp=0", ipsum_out); end
    endtask

    task automatic test_full_fill();
        vec_t m, exp;
        int   cyc;
        m = '0;
        do_start(6'd32);
        cyc = 1;
        for (int k = 0; k < 16; k++) begin
            glb_valid = 1'b1;
            glb_data  = 32'hAAAA_0000 + 32'(k);
            m = put_word(m, k, glb_data, 32);
            if (k == 15) begin
                total++; if (ipsum_valid !== 1'b0) begin bad++; $display("FAIL full_early_valid got=%b exp=0", ipsum_valid); end
            end
            tick();
            cyc++;
        end
        glb_valid = 1'b0;
        sb.push_back(m);
        total++; if (ipsum_valid !== 1'b1) begin bad++; $display("FAIL full_latency valid=%b exp=1 at cycle %0d", ipsum_valid, cyc); end
        total++; if (fill_cnt !== 5'd0) begin bad++; $display("FAIL full_fill_cnt got=%0d exp=0", fill_cnt); end
        total++; if (ipsum_out[31*16 +: 16] !== 16'h000F) begin bad++; $display("FAIL full_row31 got=%h exp=000f", ipsum_out[31*16 +: 16]); end
        exp = sb.pop_front();
        total++; if (ipsum_out !== exp) begin bad++; $display("FAIL full_data got=%h exp=%h", ipsum_out, exp); end
        last_vec = exp;
        pulse_consume();
        total++; if (ipsum_valid !== 1'b0) begin bad++; $display("FAIL full_consume got=%b exp=0", ipsum_valid); end
    endtask

    task automatic test_odd_rows();
        logic [31:0] w[3];
        vec_t m, exp;
        w[0] = 32'h1111_2222; w[1] = 32'h3333_4444; w[2] = 32'h5555_6666;
        m = '0;
        do_start(6'd5);
        for (int k = 0; k < 3; k++) begin
            if (k == 2) begin
                total++; if (ipsum_valid !== 1'b0) begin bad++; $display("FAIL odd_early_valid got=%b exp=0", ipsum_valid); end
            end
            glb_valid = 1'b1;
            glb_data  = w[k];
            m = put_word(m, k, w[k], 5);
            tick();
        end
        glb_valid = 1'b0;
        sb.push_back(m);
        total++; if (ipsum_valid !== 1'b1) begin bad++; $display("FAIL odd_valid got=%b exp=1", ipsum_valid); end
        total++; if (ipsum_out[4*16 +: 16] !== 16'h5555) begin bad++; $display("FAIL odd_row4 got=%h exp=5555", ipsum_out[4*16 +: 16]); end
        total++; if (ipsum_out[5*16 +: 16] !== 16'h0000) begin bad++; $display("FAIL odd_row5 got=%h exp=0000", ipsum_out[5*16 +: 16]); end
        exp = sb.pop_front();
        total++; if (ipsum_out !== exp) begin bad++; $display("FAIL odd_data got=%h exp=%h", ipsum_out, exp); end
        last_vec = exp;
        pulse_consume();
    endtask

    task automatic test_backpressure();
        logic [3:0]  vpat;
        logic [31:0] w[4];
        vec_t        m, exp;
        int          hs;
        vpat = 4'b1001;
        w[0] = 32'h0102_0304; w[1] = 32'hDEAD_BEEF; w[2] = 32'hCAFE_F00D; w[3] = 32'h0506_0708;
        m  = '0;
        hs = 0;
        do_start(6'd4);
        for (int j = 0; j < 4; j++) begin
            total++; if (glb_ready !== 1'b1) begin bad++; $display("FAIL bp_ready cyc=%0d got=%b exp=1", j, glb_ready); end
            total++; if (fill_cnt !== 5'(hs)) begin bad++; $display("FAIL bp_fill_cnt cyc=%0d got=%0d exp=%0d", j, fill_cnt, hs); end
            glb_valid = vpat[3-j];
            glb_data  = w[j];
            if (vpat[3-j]) begin
                m = put_word(m, hs, w[j], 4);
                hs++;
            end
            tick();
        end
        glb_valid = 1'b0;
        sb.push_back(m);
        total++; if (ipsum_valid !== 1'b1) begin bad++; $display("FAIL bp_valid got=%b exp=1", ipsum_valid); end
        exp = sb.pop_front();
        total++; if (ipsum_out !== exp) begin bad++; $display("FAIL bp_data got=%h exp=%h", ipsum_out, exp); end
        last_vec = exp;
        pulse_consume();
    endtask

    task automatic test_ignored();
        vec_t m, exp;
        do_start(6'd0);
        total++; if (glb_ready !== 1'b0) begin bad++; $display("FAIL ign_start_zero got=%b exp=0", glb_ready); end
        do_start(6'd33);
        total++; if (glb_ready !== 1'b0) begin bad++; $display("FAIL ign_start_33 got=%b exp=0", glb_ready); end
        pulse_consume();
        total++; if (ipsum_valid !== 1'b0) begin bad++; $display("FAIL ign_consume_idle got=%b exp=0", ipsum_valid); end
        total++; if (ipsum_out !== last_vec) begin bad++; $display("FAIL ign_idle_rows got=%h exp=%h", ipsum_out, last_vec); end

        // start during FILL must not change N or the word counter
        m = '0;
        do_start(6'd6);
        glb_valid = 1'b1; glb_data = 32'h1234_5678;
        m = put_word(m, 0, glb_data, 6);
        tick();
        glb_valid = 1'b0;
        start = 1'b1; row_en = 6'd32;
        tick();
        start = 1'b0;
        total++; if (fill_cnt !== 5'd1) begin bad++; $display("FAIL ign_fill_start_cnt got=%0d exp=1", fill_cnt); end
        glb_valid = 1'b1; glb_data = 32'h9ABC_DEF0;
        m = put_word(m, 1, glb_data, 6);
        tick();
        glb_data = 32'h1357_2468;
        m = put_word(m, 2, glb_data, 6);
        tick();
        glb_valid = 1'b0;
        sb.push_back(m);
        total++; if (ipsum_valid !== 1'b1) begin bad++; $display("FAIL ign_fill_start_n got=%b exp=1", ipsum_valid); end
        exp = sb.pop_front();
        total++; if (ipsum_out !== exp) begin bad++; $display("FAIL ign_fill_data got=%h exp=%h", ipsum_out, exp); end
        last_vec = exp;

        // start and consume together in FULL: consume wins, start dropped
        start = 1'b1; row_en = 6'd2; consume = 1'b1;
        tick();
        start = 1'b0; consume = 1'b0;
        total++; if (ipsum_valid !== 1'b0) begin bad++; $display("FAIL ign_sc_valid got=%b exp=0", ipsum_valid); end
        total++; if (glb_ready !== 1'b0) begin bad++; $display("FAIL ign_sc_ready got=%b exp=0", glb_ready); end
        total++; if (ipsum_out !== last_vec) begin bad++; $display("FAIL ign_sc_rows got=%h exp=%h", ipsum_out, last_vec); end
    endtask

    task automatic test_consume_restart();
        vec_t        m, exp;
        logic [31:0] w;
        m = '0;
        do_start(6'd8);
        for (int k = 0; k < 4; k++) begin
            w = $urandom;
            glb_valid = 1'b1;
            glb_data  = w;
            m = put_word(m, k, w, 8);
            tick();
        end
        glb_valid = 1'b0;
        sb.push_back(m);
        exp = sb.pop_front();
        for (int c = 0; c < 10; c++) begin
            total++;
            if (ipsum_valid !== 1'b1 || ipsum_out !== exp) begin
                bad++; $display("FAIL cr_stable cyc=%0d valid=%b got=%h exp=%h", c, ipsum_valid, ipsum_out, exp);
            end
            tick();
        end
        pulse_consume();
        total++; if (ipsum_valid !== 1'b0) begin bad++; $display("FAIL cr_consume got=%b exp=0", ipsum_valid); end
        do_start(6'd2);
        total++; if (ipsum_out !== '0) begin bad++; $display("FAIL cr_clear got=%h exp=0", ipsum_out); end
        m = '0;
        glb_valid = 1'b1; glb_data = 32'hFFFF_8001;
        m = put_word(m, 0, glb_data, 2);
        sb.push_back(m);
        tick();
        glb_valid = 1'b0;
        total++; if (ipsum_valid !== 1'b1) begin bad++; $display("FAIL cr_restart_valid got=%b exp=1", ipsum_valid); end
        exp = sb.pop_front();
        total++; if (ipsum_out !== exp) begin bad++; $display("FAIL cr_restart_data got=%h exp=%h", ipsum_out, exp); end
        last_vec = exp;
        pulse_consume();
    endtask

    task automatic test_async_reset();
        do_start(6'd16);
        for (int k = 0; k < 3; k++) begin
            glb_valid = 1'b1;
            glb_data  = 32'h7000_0000 + 32'(k);
            tick();
        end
        glb_valid = 1'b0;
        #2 reset = 1'b1;
        #1;
        total++; if (glb_ready !== 1'b0) begin bad++; $display("FAIL ar_ready got=%b exp=0", glb_ready); end
        total++; if (ipsum_valid !== 1'b0) begin bad++; $display("FAIL ar_valid got=%b exp=0", ipsum_valid); end
        total++; if (fill_cnt !== 5'd0) begin bad++; $display("FAIL ar_fill_cnt got=%0d exp=0", fill_cnt); end
        total++; if (ipsum_out !== '0) begin bad++; $display("FAIL ar_rows got=%h exp=0", ipsum_out); end
        #1 reset = 1'b0;
        tick();
        total++; if (glb_ready !== 1'b0) begin bad++; $display("FAIL ar_post_idle got=%b exp=0", glb_ready); end
    endtask

    initial begin
        test_reset();
        test_full_fill();
        test_odd_rows();
        test_backpressure();
        test_ignored();
        test_consume_restart();
        test_async_reset();
        total++; if (sb.size() != 0) begin bad++; $display("FAIL sb_drain got=%0d exp=0", sb.size()); end
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog got=timeout exp=finish");
        $fatal(1, "watchdog expired");
    end

endmodule
`default_nettype wire
